// File: rtl/seg7_reader_if.sv
// rtl/seg7_reader_if.sv - display bus pair in, decoded digits and status out
interface seg7_reader_if;
   logic [6:0] DISP0;
   logic [6:0] DISP1;
   logic [3:0] DIGIT0;
   logic [3:0] DIGIT1;
   logic       VALID;
   logic [1:0] BLANK;
   logic [1:0] ERR;
   logic [7:0] ERR_COUNT;

   modport master (
      output DISP0, DISP1,
      input  DIGIT0, DIGIT1, VALID, BLANK, ERR, ERR_COUNT
   );

   modport slave (
      input  DISP0, DISP1,
      output DIGIT0, DIGIT1, VALID, BLANK, ERR, ERR_COUNT
   );
endinterface

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - recover hex digits from two active-low 7-segment buses
module seg7_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   seg7_reader_if.slave bus
);
   localparam int unsigned      CNT_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   typedef struct packed {
      logic       err;
      logic       blank;
      logic [3:0] digit;
   } dec_t;

   function automatic dec_t decode_seg(input logic [6:0] seg);
      dec_t d;
      d = '0;
      case (seg)
         7'h40:   d.digit = 4'h0;
         7'h79:   d.digit = 4'h1;
         7'h24:   d.digit = 4'h2;
         7'h30:   d.digit = 4'h3;
         7'h19:   d.digit = 4'h4;
         7'h12:   d.digit = 4'h5;
         7'h02:   d.digit = 4'h6;
         7'h78:   d.digit = 4'h7;
         7'h00:   d.digit = 4'h8;
         7'h10:   d.digit = 4'h9;
         7'h08:   d.digit = 4'hA;
         7'h03:   d.digit = 4'hB;
         7'h46:   d.digit = 4'hC;
         7'h21:   d.digit = 4'hD;
         7'h06:   d.digit = 4'hE;
         7'h0E:   d.digit = 4'hF;
         7'h7F:   d.blank = 1'b1;
         default: d.err   = 1'b1;
      endcase
      return d;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [13:0]      last_q, last_d;
   logic [13:0]      rep_q, rep_d;
   logic             first_q, first_d;
   logic [3:0]       digit0_q, digit0_d;
   logic [3:0]       digit1_q, digit1_d;
   logic [1:0]       blank_q, blank_d;
   logic [1:0]       err_q, err_d;
   logic [7:0]       err_count_q, err_count_d;
   logic             valid_q, valid_d;

   logic [13:0]      pair_in;
   logic             same;
   logic             counting;
   logic [CNT_W-1:0] cnt_next;
   logic             accept;
   logic             report;
   dec_t             dec0, dec1;

   assign pair_in  = {bus.DISP1, bus.DISP0};
   assign same     = (pair_in == last_q);
   assign dec0     = decode_seg(bus.DISP0);
   assign dec1     = decode_seg(bus.DISP1);

   // A change seen while locked restarts the count with the new pair as sample one,
   // so with STABLE_CYCLES=1 it is accepted on that very edge.
   assign counting = (state_q == SEARCH) || !same;
   assign cnt_next = ((state_q == SEARCH) && same) ? cnt_q + CNT_ONE : CNT_ONE;
   assign accept   = counting && (cnt_next == CNT_TARGET);
   assign report   = accept && (first_q || (pair_in != rep_q));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      rep_d       = rep_q;
      first_d     = first_q;
      digit0_d    = digit0_q;
      digit1_d    = digit1_q;
      blank_d     = blank_q;
      err_d       = err_q;
      err_count_d = err_count_q;
      valid_d     = 1'b0;

      if (counting) begin
         cnt_d   = cnt_next;
         last_d  = pair_in;
         state_d = accept ? LOCKED : SEARCH;
      end

      // Re-locking onto the pair already reported (after a glitch) stays silent.
      if (report) begin
         digit0_d = dec0.digit;
         digit1_d = dec1.digit;
         blank_d  = {dec1.blank, dec0.blank};
         err_d    = {dec1.err, dec0.err};
         rep_d    = pair_in;
         first_d  = 1'b0;
         valid_d  = 1'b1;
         if ((dec0.err || dec1.err) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SEARCH;
         cnt_q       <= '0;
         last_q      <= '0;
         rep_q       <= '0;
         first_q     <= 1'b1;
         digit0_q    <= '0;
         digit1_q    <= '0;
         blank_q     <= '0;
         err_q       <= '0;
         err_count_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         rep_q       <= rep_d;
         first_q     <= first_d;
         digit0_q    <= digit0_d;
         digit1_q    <= digit1_d;
         blank_q     <= blank_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
         valid_q     <= valid_d;
      end
   end

   assign bus.DIGIT0    = digit0_q;
   assign bus.DIGIT1    = digit1_q;
   assign bus.BLANK     = blank_q;
   assign bus.ERR       = err_q;
   assign bus.ERR_COUNT = err_count_q;
   assign bus.VALID     = valid_q;
endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - scoreboard bench for seg7_reader at STABLE_CYCLES 4 and 1
module tb_seg7_reader;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seg7_reader_if if4 ();
   seg7_reader_if if1 ();

   seg7_reader #(.STABLE_CYCLES(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
   seg7_reader #(.STABLE_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

   typedef struct packed {
      logic [3:0] d0;
      logic [3:0] d1;
      logic [1:0] blank;
      logic [1:0] err;
      logic [7:0] ec;
   } obs_t;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   obs_t q4[$];
   obs_t q1[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // reference model state: index 0 is the STABLE_CYCLES=4 instance, 1 the =1 instance
   int          need  [2] = '{4, 1};
   int          run   [2];
   logic [13:0] prev  [2];
   logic [13:0] rep   [2];
   bit          first [2];
   int          ec    [2];

   task automatic check(input bit ok, input string name, input string info);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, info);
   endtask

   function automatic void ref_decode(input logic [6:0] s, output logic [3:0] d,
                                      output logic b, output logic e);
      d = 4'h0; b = 1'b0; e = 1'b0;
      if (s == 7'h7F) b = 1'b1;
      else begin
         e = 1'b1;
         for (int i = 0; i < 16; i++)
            if (seg_tab[i] == s) begin d = 4'(i); e = 1'b0; end
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         run[k] = 0; prev[k] = '0; rep[k] = '0; first[k] = 1'b1; ec[k] = 0;
      end
      q4.delete();
      q1.delete();
   endfunction

   // A pair is accepted on the edge where its unbroken run length equals the stability need.
   function automatic void model_edge(input logic [13:0] pair);
      obs_t o;
      logic b0, b1, e0, e1;
      for (int k = 0; k < 2; k++) begin
         if (run[k] > 0 && pair == prev[k]) run[k]++;
         else run[k] = 1;
         prev[k] = pair;
         if (run[k] == need[k] && (first[k] || pair != rep[k])) begin
            first[k] = 1'b0;
            rep[k]   = pair;
            ref_decode(pair[6:0], o.d0, b0, e0);
            ref_decode(pair[13:7], o.d1, b1, e1);
            o.blank = {b1, b0};
            o.err   = {e1, e0};
            if ((e0 || e1) && ec[k] < 255) ec[k]++;
            o.ec = 8'(ec[k]);
            if (k == 0) q4.push_back(o);
            else q1.push_back(o);
         end
      end
   endfunction

   task automatic set_inputs(input logic [6:0] d0, input logic [6:0] d1);
      if4.DISP0 = d0; if4.DISP1 = d1;
      if1.DISP0 = d0; if1.DISP1 = d1;
   endtask

   // called at a falling edge; the following rising edge samples this pair
   task automatic step(input logic [6:0] d0, input logic [6:0] d1);
      set_inputs(d0, d1);
      model_edge({d1, d0});
      @(negedge clk);
   endtask

   task automatic hold(input logic [6:0] d0, input logic [6:0] d1, input int n);
      for (int i = 0; i < n; i++) step(d0, d1);
   endtask

   function automatic logic [6:0] rand_seg();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return seg_tab[$urandom_range(0, 15)];
      else if (r == 7) return 7'h7F;
      else return 7'($urandom_range(0, 127));
   endfunction

   function automatic obs_t got4();
      return {if4.DIGIT0, if4.DIGIT1, if4.BLANK, if4.ERR, if4.ERR_COUNT};
   endfunction

   function automatic obs_t got1();
      return {if1.DIGIT0, if1.DIGIT1, if1.BLANK, if1.ERR, if1.ERR_COUNT};
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("d0=%h d1=%h blank=%b err=%b ec=%0d", o.d0, o.d1, o.blank, o.err, o.ec);
   endfunction

   task automatic check_clear(input string name);
      check(got4() == '0 && if4.VALID == 1'b0, {name, "_n4"},
            $sformatf("got valid=%b %s, expected all zero", if4.VALID, fmt(got4())));
      check(got1() == '0 && if1.VALID == 1'b0, {name, "_n1"},
            $sformatf("got valid=%b %s, expected all zero", if1.VALID, fmt(got1())));
   endtask

   // monitor: every VALID must match the head of its queue, and every queued item needs a VALID
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (if4.VALID || q4.size() != 0) begin
            if (q4.size() == 0)
               check(1'b0, "n4_unexpected_valid", $sformatf("got VALID with %s, expected none", fmt(got4())));
            else begin
               e = q4.pop_front();
               check(if4.VALID && got4() == e, "n4_report",
                     $sformatf("got valid=%b %s, expected valid=1 %s", if4.VALID, fmt(got4()), fmt(e)));
            end
         end
         if (if1.VALID || q1.size() != 0) begin
            if (q1.size() == 0)
               check(1'b0, "n1_unexpected_valid", $sformatf("got VALID with %s, expected none", fmt(got1())));
            else begin
               e = q1.pop_front();
               check(if1.VALID && got1() == e, "n1_report",
                     $sformatf("got valid=%b %s, expected valid=1 %s", if1.VALID, fmt(got1()), fmt(e)));
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      set_inputs(7'h7F, 7'h7F);
      model_reset();
      repeat (2) @(negedge clk);
      check_clear("reset_state");

      reset = 1'b1;
      hold(7'h40, 7'h79, 6);

      hold(7'h24, 7'h79, 3);
      hold(7'h40, 7'h79, 5);
      hold(7'h24, 7'h79, 5);

      for (int i = 0; i < 16; i++) hold(seg_tab[i], seg_tab[15 - i], 4);

      for (int i = 0; i < 300; i++) begin
         hold(7'h7F, 7'h55, 4);
         hold(7'h40, 7'h79, 4);
      end
      check(if4.ERR_COUNT == 8'd255, "n4_err_count_sat", $sformatf("got %0d, expected 255", if4.ERR_COUNT));
      check(if1.ERR_COUNT == 8'd255, "n1_err_count_sat", $sformatf("got %0d, expected 255", if1.ERR_COUNT));

      hold(7'h24, 7'h30, 3);
      #1;
      reset = 1'b0;
      #1;
      model_reset();
      check_clear("reset_midcount");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      hold(7'h24, 7'h30, 5);

      for (int i = 0; i < 200; i++) hold(rand_seg(), rand_seg(), $urandom_range(1, 6));

      hold(7'h7F, 7'h7F, 5);
      for (int i = 0; i < 5; i++) step(seg_tab[i], seg_tab[i + 6]);
      hold(seg_tab[4], seg_tab[10], 4);

      repeat (3) @(negedge clk);
      check(q4.size() == 0, "n4_queue_drained", $sformatf("got %0d pending, expected 0", q4.size()));
      check(q1.size() == 0, "n1_queue_drained", $sformatf("got %0d pending, expected 0", q1.size()));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
